// File: rtl/mfp_7seg_scan_controller_pkg.sv
// mfp_7seg_scan_controller_pkg: shared glyph table, blank pattern and parameter legality check
package mfp_7seg_scan_controller_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Active-low g..a patterns for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic bit params_ok(int scan_div, int dead_cycles, int pwm_bits);
    return scan_div > 1 && (scan_div & (scan_div - 1)) == 0 && scan_div >= (1 << pwm_bits)
      && dead_cycles >= 1 && dead_cycles < scan_div;
  endfunction
endpackage

// File: rtl/mfp_hex_to_7seg.sv
// mfp_hex_to_7seg: combinational nibble to active-low 7-segment decoder
module mfp_hex_to_7seg
  import mfp_7seg_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);
  assign seg_n = SEG_GLYPH[nibble];
endmodule

// File: rtl/mfp_7seg_scan_controller.sv
// mfp_7seg_scan_controller: time-multiplexed 7-segment scan with dead time and PWM brightness
module mfp_7seg_scan_controller
  import mfp_7seg_scan_controller_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_DIV    = 1024,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS    = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] hex,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  if (!params_ok(SCAN_DIV, DEAD_CYCLES, PWM_BITS)) begin : g_bad_params
    $error("mfp_7seg_scan_controller: illegal SCAN_DIV/DEAD_CYCLES/PWM_BITS");
  end
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          sh_nib;
  logic                sh_en;
  logic                sh_dp;
  logic [PWM_BITS-1:0] sh_br;
  logic [6:0]          glyph;
  logic                slot_end;
  logic                frame_end;
  logic                lit;
  mfp_hex_to_7seg u_dec (.nibble(sh_nib), .seg_n(glyph));
  assign slot_end  = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == IW'(N_DIGITS - 1);
  // Dead time first, then the PWM window measured on the slot counter's top bits.
  assign lit = enable && cnt >= CW'(DEAD_CYCLES) && sh_en
    && (sh_br == '1 || cnt[CW-1 -: PWM_BITS] < sh_br);
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt        <= '0;
      idx        <= '0;
      sh_nib     <= '0;
      sh_en      <= 1'b0;
      sh_dp      <= 1'b0;
      sh_br      <= '0;
      anode_n    <= '1;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= cnt + 1'b1;
        if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
        if (cnt == '0) begin
          sh_nib <= hex[4*idx +: 4];
          sh_en  <= digit_en[idx];
          sh_dp  <= dp[idx];
          sh_br  <= brightness;
        end
      end
      anode_n    <= lit ? ~(N_DIGITS'(1) << idx) : '1;
      seg_n      <= lit ? glyph : SEG_BLANK;
      dp_n       <= lit ? ~sh_dp : 1'b1;
      frame_tick <= enable && frame_end;
    end
  end
endmodule
